// File: rtl/slow_clk_monitor_pkg.sv
// Shared constants and FSM encoding for the divided-clock monitor.
// Defaults derive from the divider's toggle constant so both ends agree.
package slow_clk_monitor_pkg;

  localparam int DIV_TOGGLE       = 625000;
  localparam int DEF_NOMINAL_HALF = DIV_TOGGLE + 1;
  localparam int DEF_TOLERANCE    = 16;
  localparam int DEF_LOCK_COUNT   = 4;
  localparam int DEF_TIMEOUT      = 2 * DEF_NOMINAL_HALF;
  localparam int DEF_CNT_W        = $clog2(DEF_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } mon_state_e;

endpackage

// File: rtl/slow_clk_monitor_sync_edge_detect.sv
// Two-flop synchroniser plus history flop for slow_in, producing
// registered one-cycle rise/fall strobes in the clk_in domain.
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic slow_in,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= slow_in;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/slow_clk_monitor.sv
// Monitors the divided clock: edge strobes, half-period measurement,
// lock acquisition over consecutive good half periods, and edge timeout.
module slow_clk_monitor
  import slow_clk_monitor_pkg::*;
#(
  parameter int NOMINAL_HALF = DEF_NOMINAL_HALF,
  parameter int TOLERANCE    = DEF_TOLERANCE,
  parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(NOMINAL_HALF - TOLERANCE);
  localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(NOMINAL_HALF + TOLERANCE);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic             rise, fall;
  logic             edge_cyc, good;
  logic [CNT_W-1:0] cnt, meas;
  logic [GC_W-1:0]  gcnt;
  mon_state_e       state;

  sync_edge_detect u_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .slow_in (slow_in),
    .rise    (rise),
    .fall    (fall)
  );

  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    edge_cyc = rise | fall;
    meas     = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    good     = (meas >= WIN_LO) && (meas <= WIN_HI);
  end

  // NOTE: synchronous active-high reset; only plain flops here, no memory arrays.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      cnt          <= '0;
      gcnt         <= '0;
      state        <= ST_IDLE;
    end else begin
      rise_pulse   <= rise;
      fall_pulse   <= fall;
      period_valid <= 1'b0;
      if (edge_cyc) begin
        cnt     <= '0;
        timeout <= 1'b0;
        if (state == ST_IDLE) begin
          // First edge after reset or timeout only starts timing.
          state  <= ST_ACQ;
          gcnt   <= '0;
          locked <= 1'b0;
        end else begin
          period_valid <= 1'b1;
          half_period  <= meas;
          if (!good) begin
            state  <= ST_ACQ;
            gcnt   <= '0;
            locked <= 1'b0;
          end else if (state == ST_ACQ) begin
            gcnt <= gcnt + 1'b1;
            if (gcnt == GC_W'(LOCK_COUNT - 1)) begin
              state  <= ST_LOCK;
              locked <= 1'b1;
            end
          end
        end
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (cnt == TO_LAST) begin
          state   <= ST_IDLE;
          gcnt    <= '0;
          locked  <= 1'b0;
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/slow_clk_monitor.md
# slow_clk_monitor

Receiving end of the divided-clock path: takes the slow toggling clock produced by the 25 MHz divider (nominal 50 ms period) back into the `clk_in` domain. It synchronises the signal and emits single-cycle edge strobes, measures every half period, and reports lock or timeout. Downstream lock/VGA logic uses the strobes as enables instead of clocking flops from the divided clock, and uses `locked` as a health flag.

## Interface
- `NOMINAL_HALF`, 625001: expected `clk_in` cycles between successive toggles of `slow_in`.
- `TOLERANCE`, 16: allowed |measured − NOMINAL_HALF| for a half period to count as good.
- `LOCK_COUNT`, 4: consecutive good half periods required to assert `locked`.
- `TIMEOUT`, 1250002: cycles without an edge before `timeout` asserts.
- `CNT_W`, 21: width of the measurement counter. It must hold TIMEOUT; the minimum legal value is ceil(log2(TIMEOUT+1)).

Ports:
- `clk_in`  input  1  25 MHz system clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `slow_in`  input  1  divided clock, treated as asynchronous.
- `rise_pulse`  output  1  one-cycle strobe on a synchronised rising edge.
- `fall_pulse`  output  1  one-cycle strobe on a synchronised falling edge.
- `half_period`  output  CNT_W  last measured edge-to-edge interval in cycles.
- `period_valid`  output  1  one-cycle strobe when `half_period` updates.
- `locked`  output  1  level; lock acquired.
- `timeout`  output  1  level; no edge for TIMEOUT cycles.

## Operation
- Synchroniser: two flops `s1` and `s2`, then a history flop `s3`. Edge = `s2 ^ s3`; rise = `s2 & ~s3`; fall = `~s2 & s3`.
- Counter `cnt`:
  - Increments each cycle.
  - Saturates at 2^CNT_W−1 and never wraps.
  - On an edge cycle it loads 0.
- Measurement: on an edge cycle, the measured value = `cnt` + 1, saturated.
  - The first edge after reset only starts timing. It produces no `period_valid` and leaves `half_period` unchanged.
- Good measurement: NOMINAL_HALF−TOLERANCE ≤ measured ≤ NOMINAL_HALF+TOLERANCE, inclusive bounds.
- FSM states: IDLE, ACQ, LOCK. A good-count register `gcnt` runs 0..LOCK_COUNT.
  - IDLE: first edge → ACQ, `gcnt`=0.
  - ACQ: a good measurement increments `gcnt`. When it reaches LOCK_COUNT → LOCK. A bad measurement sets `gcnt`=0 and stays in ACQ.
  - LOCK: a bad measurement → ACQ, `gcnt`=0.
  - Timeout from any state → IDLE. The next edge restarts acquisition as a first edge, with no measurement.
- `locked` = (state == LOCK), registered.
- `timeout`:
  - Sets when `cnt` reaches TIMEOUT−1 with no edge in that cycle.
  - Holds until the next edge, and clears on the same edge that produces that edge's strobe.
- Simultaneous edge and timeout condition in one cycle: the edge wins. No timeout is raised.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - The synchroniser flops also reset to 0. A `slow_in` already high at reset release therefore produces a `rise_pulse`, treated as the first edge.

## Timing
- Reset values: `rise_pulse`=0, `fall_pulse`=0, `half_period`=0, `period_valid`=0, `locked`=0, `timeout`=0; `s1`/`s2`/`s3`=0; `cnt`=0; state=IDLE.
- All outputs are registered.
- Latency: `slow_in` sampled high at clock edge k produces `rise_pulse` high for exactly the cycle after edge k+3.
- `period_valid`, the `half_period` update, the `locked` change and the `timeout` clear all occur on the same edge as the corresponding pulse.
- Steady-state spacing: with a perfect divider, pulses are exactly NOMINAL_HALF cycles apart and measured = NOMINAL_HALF.
- `timeout` asserts TIMEOUT cycles after the last edge cycle.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE/ACQ/LOCK);
  - default NOMINAL_HALF, TIMEOUT and CNT_W, derived from the divider's toggle constant 625000 as NOMINAL_HALF = toggle+1, so divider and monitor cannot drift apart.
- One natural sub-module: `sync_edge_detect`, covering the two-flop synchroniser, history flop and rise/fall strobes.
- Counter, comparator and FSM live in the top.

## Test plan
Bench parameters: NOMINAL_HALF=10, TOLERANCE=1, LOCK_COUNT=4, TIMEOUT=20, CNT_W=5.
- Reset, then `slow_in` toggling every 10 cycles:
  - first rise gives `rise_pulse` 4 cycles after the input change, with no `period_valid`;
  - every following edge gives `period_valid` with `half_period`=10;
  - `locked`=1 on the 4th measured edge.
- Locked, then one half period of 12: `half_period`=12, `locked` drops on that edge. Four more intervals of 10 (each 9 or 11 also qualifies) re-lock.
- Locked, then `slow_in` held static: `timeout`=1 exactly 20 cycles after the last edge and `locked`=0. The next edge clears `timeout` with no `period_valid`.
- Edge arriving exactly at cycle 19 after the previous edge: no timeout, `half_period`=20, counted as bad.
- `rst` pulsed mid-lock with `slow_in` high: all outputs 0 next cycle. After release, `rise_pulse` fires once, treated as the first edge.
- Glitch shorter than one `clk_in` period straddling no edge: no strobe. Randomised toggle phase: `rise_pulse` and `fall_pulse` are never simultaneous.
